// File: rtl/stack_drain_if.sv
// Output stream of the stack drain engine: data with a valid/ready handshake.
interface stack_drain_if #(
  parameter int B = 8
) ();
  logic [B-1:0] m_data;
  logic         m_valid;
  logic         m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/stack_drain.sv
// Pops a requested number of entries from an external LIFO and streams them
// out newest first, while tracking stack occupancy from push and pop strobes.
module stack_drain #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            start,
  input  logic [W:0]      len,
  output logic            stk_pop,
  input  logic [B-1:0]    stk_data,
  stack_drain_if.master   m,
  output logic [W:0]      level,
  output logic            busy,
  output logic            done,
  output logic            uf,
  output logic            of
);

  typedef enum logic [1:0] {IDLE, POP, FLUSH, DONE} state_t;

  localparam logic [W:0] FULL = {1'b1, {W{1'b0}}};

  state_t       state_reg, state_next;
  logic [W:0]   level_reg, level_next;
  logic [W:0]   remaining_reg, remaining_next;
  logic [B-1:0] data_reg, data_next;
  logic         valid_reg, valid_next;
  logic         busy_reg, busy_next;
  logic         done_reg, done_next;
  logic         uf_reg, uf_next;
  logic         of_reg, of_next;
  logic         pop;
  logic         slot_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      level_reg     <= '0;
      remaining_reg <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      uf_reg        <= 1'b0;
      of_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      level_reg     <= level_next;
      remaining_reg <= remaining_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      uf_reg        <= uf_next;
      of_reg        <= of_next;
    end
  end

  // The output register can take a new beat when empty or being drained.
  assign slot_free = !valid_reg || m.m_ready;

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    data_next      = data_reg;
    valid_next     = valid_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    uf_next        = 1'b0;
    pop            = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_next = DONE;
          end else if (len > level_reg) begin
            uf_next = 1'b1;
          end else begin
            remaining_next = len;
            busy_next      = 1'b1;
            state_next     = POP;
          end
        end
      end
      POP: begin
        if (slot_free) begin
          if (level_reg != '0) begin
            pop            = 1'b1;
            data_next      = stk_data;
            valid_next     = 1'b1;
            remaining_next = remaining_reg - 1'b1;
            if (remaining_reg == 1) begin
              state_next = FLUSH;
            end
          end else begin
            // Slot was freed by acceptance but nothing to pop: retire the beat.
            valid_next = 1'b0;
          end
        end
      end
      FLUSH: begin
        if (valid_reg && m.m_ready) begin
          valid_next = 1'b0;
          state_next = DONE;
        end
      end
      DONE: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    level_next = level_reg;
    of_next    = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (level_reg == FULL) begin
          of_next = 1'b1;
        end else begin
          level_next = level_reg + 1'b1;
        end
      end
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  assign stk_pop   = pop;
  assign m.m_data  = data_reg;
  assign m.m_valid = valid_reg;
  assign level     = level_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign uf        = uf_reg;
  assign of        = of_reg;

endmodule

// File: tb/tb_stack_drain.sv
// Bench for stack_drain: a behavioural LIFO feeds the engine, and a queue model
// of intended stack contents predicts the beats, level and pulse counts.
module tb_stack_drain;
  localparam int B = 8;
  localparam int W = 4;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         push = 1'b0;
  logic         start = 1'b0;
  logic [W:0]   len = '0;
  logic         stk_pop;
  logic [B-1:0] stk_data;
  logic [W:0]   level;
  logic         busy, done, uf, of;
  logic [B-1:0] push_data = '0;

  stack_drain_if #(.B(B)) m ();

  stack_drain #(.B(B), .W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .start    (start),
    .len      (len),
    .stk_pop  (stk_pop),
    .stk_data (stk_data),
    .m        (m),
    .level    (level),
    .busy     (busy),
    .done     (done),
    .uf       (uf),
    .of       (of)
  );

  always #5 clk = ~clk;

  // External stack memory driven by the strobes.
  logic [B-1:0] mem [DEPTH];
  int           cnt = 0;
  assign stk_data = (cnt > 0) ? mem[cnt-1] : '0;

  always @(posedge clk) begin
    if (reset) begin
      cnt <= 0;
    end else if (push && stk_pop) begin
      mem[cnt-1] <= push_data;
    end else if (push && cnt < DEPTH) begin
      mem[cnt] <= push_data;
      cnt <= cnt + 1;
    end else if (stk_pop && cnt > 0) begin
      cnt <= cnt - 1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [B-1:0] ref_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor sampled on the falling edge, between input changes.
  int cyc = 0;
  int pop_cnt = 0, done_cnt = 0, uf_cnt = 0, of_cnt = 0;
  int start_cyc = -1, first_pop_cyc = -1, first_valid_cyc = -1;
  int first_acc_cyc = -1, last_acc_cyc = -1, done_cyc = -1;
  logic [B-1:0] beats [$];
  logic prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b1;
  logic [B-1:0] prev_d = '0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (stk_pop) begin
        pop_cnt++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        check("pop_nonempty", {31'b0, level != 0}, 32'd1);
      end
      if (m.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m.m_valid && m.m_ready) begin
        beats.push_back(m.m_data);
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (uf) uf_cnt++;
      if (of) of_cnt++;
      if (!prev_rst && prev_v && !prev_r) begin
        check("hold_valid", {31'b0, m.m_valid}, 32'd1);
        check("hold_data", {24'b0, m.m_data}, {24'b0, prev_d});
      end
    end
    prev_v   = m.m_valid;
    prev_r   = m.m_ready;
    prev_d   = m.m_data;
    prev_rst = reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [B-1:0] d);
    push = 1'b1;
    push_data = d;
    tick();
    push = 1'b0;
    if (ref_q.size() < DEPTH) ref_q.push_back(d);
    $display("push %02h level_model %0d", d, ref_q.size());
  endtask

  task automatic start_drain(input int n);
    beats.delete();
    first_pop_cyc = -1; first_valid_cyc = -1;
    first_acc_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
    start = 1'b1;
    len = n[W:0];
    start_cyc = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready high, 1: toggling, 2: random
  task automatic wait_done(input int mode, input int d0, input string tag);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      case (mode)
        0:       m.m_ready = 1'b1;
        1:       m.m_ready = ~n[0];
        default: m.m_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      n++;
    end
    tick();
    check({tag, "_done_once"}, done_cnt - d0, 32'd1);
    m.m_ready = 1'b0;
  endtask

  task automatic check_beats(input string tag, input int n);
    logic [B-1:0] e;
    check({tag, "_beats"}, beats.size(), n);
    for (int i = 0; i < n; i++) begin
      e = ref_q.pop_back();
      check({tag, "_beat"}, (i < beats.size()) ? {24'b0, beats[i]} : 32'hdead, {24'b0, e});
    end
  endtask

  task automatic full_drain(input int n, input int mode, input string tag);
    int d0, p0;
    d0 = done_cnt;
    p0 = pop_cnt;
    start_drain(n);
    wait_done(mode, d0, tag);
    check_beats(tag, n);
    check({tag, "_pops"}, pop_cnt - p0, n);
    check({tag, "_level"}, level, ref_q.size());
    check({tag, "_busy"}, busy, 32'd0);
    $display("drain %s len %0d beats %0d level %0d", tag, n, beats.size(), level);
  endtask

  task automatic reject(input int n, input string tag);
    int u0, p0, d0;
    u0 = uf_cnt; p0 = pop_cnt; d0 = done_cnt;
    start_drain(n);
    repeat (3) tick();
    check({tag, "_uf"}, uf_cnt - u0, 32'd1);
    check({tag, "_nopop"}, pop_cnt - p0, 32'd0);
    check({tag, "_nodone"}, done_cnt - d0, 32'd0);
    check({tag, "_level"}, level, ref_q.size());
    $display("reject %s len %0d level %0d", tag, n, level);
  endtask

  task automatic zero_len(input string tag);
    int p0, d0;
    p0 = pop_cnt; d0 = done_cnt;
    start_drain(0);
    repeat (3) tick();
    check({tag, "_done"}, done_cnt - d0, 32'd1);
    check({tag, "_nopop"}, pop_cnt - p0, 32'd0);
    check({tag, "_busy"}, busy, 32'd0);
    $display("zero_len %s", tag);
  endtask

  initial begin
    int d0, p0, o0, k, n;
    logic [B-1:0] top;
    m.m_ready = 1'b0;
    repeat (3) tick();
    check("rst_level", level, 32'd0);
    check("rst_valid", m.m_valid, 32'd0);
    check("rst_data", m.m_data, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_flags", {done, uf, of, stk_pop}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic newest-first drain with latency checks
    do_push(8'h11); do_push(8'h22); do_push(8'h33);
    check("t1_level", level, 32'd3);
    full_drain(3, 0, "t1");
    check("t1_pop_lat", first_pop_cyc - start_cyc, 32'd1);
    check("t1_valid_lat", first_valid_cyc - start_cyc, 32'd2);
    check("t1_back2back", last_acc_cyc - first_acc_cyc, 32'd2);
    check("t1_done_lat", done_cyc - last_acc_cyc, 32'd2);

    // Underflow rejection, then confirm the engine still accepts work
    do_push(8'h44); do_push(8'h55);
    reject(3, "t2");
    full_drain(2, 2, "t2_after");

    // Fill, overflow, drain with toggling ready
    for (int i = 0; i < DEPTH; i++) do_push(8'($urandom));
    check("t3_full", level, 32'd16);
    o0 = of_cnt;
    do_push(8'hEE);
    tick();
    check("t3_of", of_cnt - o0, 32'd1);
    check("t3_full_hold", level, 32'd16);
    full_drain(16, 1, "t3");

    // Stalled consumer allows only one pop
    for (int i = 0; i < 4; i++) do_push(8'($urandom));
    d0 = done_cnt; p0 = pop_cnt;
    start_drain(2);
    repeat (5) tick();
    check("t4_one_pop", pop_cnt - p0, 32'd1);
    check("t4_valid_held", m.m_valid, 32'd1);
    check("t4_data_top", m.m_data, ref_q[ref_q.size()-1]);
    wait_done(0, d0, "t4");
    check("t4_pops", pop_cnt - p0, 32'd2);
    check_beats("t4", 2);
    check("t4_level", level, 32'd2);

    // Push between the two pops of a drain
    do_push(8'($urandom));
    d0 = done_cnt;
    start_drain(2);
    tick(); tick();
    push = 1'b1; push_data = 8'h99;
    tick();
    push = 1'b0;
    wait_done(0, d0, "t5");
    top = ref_q.pop_back();
    check("t5_beats", beats.size(), 32'd2);
    check("t5_beat0", beats[0], top);
    check("t5_beat1", beats[1], 32'h99);
    check("t5_level", level, 32'd2);
    check("t5_level_model", level, ref_q.size());

    // Zero length, then reset mid-drain
    zero_len("t6");
    start_drain(2);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ref_q.delete();
    check("t6_rst_valid", m.m_valid, 32'd0);
    check("t6_rst_busy", busy, 32'd0);
    check("t6_rst_level", level, 32'd0);
    check("t6_rst_data", m.m_data, 32'd0);
    tick();

    // Randomized push bursts and drain requests
    for (int it = 0; it < 25; it++) begin
      k = $urandom_range(0, DEPTH - ref_q.size());
      for (int i = 0; i < k; i++) do_push(8'($urandom));
      n = $urandom_range(0, ref_q.size() + 2);
      if (n == 0) zero_len("rnd_zero");
      else if (n > ref_q.size()) reject(n, "rnd_rej");
      else full_drain(n, 2, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
